// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

    localparam int DATA_W     = 16;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Address is legal when every bit above the array index is zero.
    function automatic logic addr_in_range(input logic [15:0] addr, input int abits);
        return ((addr >> abits) == 16'h0000);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 2**ADDR_BITS x DATA_W, with registered read.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 we,
    input  logic                 clr,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    din,
    output logic [DATA_W-1:0]    q
);

    logic [DATA_W-1:0] mem_r [0:(2**ADDR_BITS)-1];

    // Array write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_r[addr] <= din;
        end
    end

    // Read register; clr returns zero instead of array data for illegal reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {DATA_W{1'b0}};
        end else if (en && !we) begin
            q <= clr ? {DATA_W{1'b0}} : mem_r[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts read/write requests, returns reads after RD_LATENCY clocks.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_BITS  = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        DMem_en,
    input  logic [15:0] DMem_addr,
    input  logic [15:0] Dmem_din,
    input  logic        DMem_rd,
    output logic [15:0] memout,
    output logic        rd_valid,
    output logic        wr_ack,
    output logic        mem_ready,
    output logic        addr_err
);

    generate
        if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
            $fatal(1, "dmem_responder: RD_LATENCY out of range 1..4");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LOAD =
        (RD_LATENCY > 1) ? CNT_W'(RD_LATENCY - 2) : {CNT_W{1'b0}};

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [ADDR_BITS-1:0]   addr_r;
    logic                   oor_r;
    logic                   rd_valid_r;
    logic                   wr_ack_r;
    logic                   mem_ready_r;
    logic                   addr_err_r;

    logic                   accept_s;
    logic                   in_range_s;
    logic                   read_done_s;
    logic                   ram_en_s;
    logic                   ram_we_s;
    logic                   ram_clr_s;
    logic [ADDR_BITS-1:0]   ram_addr_s;
    logic [DATA_W-1:0]      ram_q_s;

    assign accept_s    = DMem_en && mem_ready_r;
    assign in_range_s  = addr_in_range(DMem_addr, ADDR_BITS);
    assign read_done_s = (state_r == WAIT) && (cnt_r == {CNT_W{1'b0}});

    // The RAM read fires on the edge that completes the read, so the RAM
    // read register doubles as the held memout value for every latency.
    always_comb begin
        ram_en_s   = 1'b0;
        ram_we_s   = 1'b0;
        ram_clr_s  = 1'b0;
        ram_addr_s = DMem_addr[ADDR_BITS-1:0];
        if (read_done_s) begin
            ram_en_s   = 1'b1;
            ram_clr_s  = oor_r;
            ram_addr_s = addr_r;
        end else if (accept_s && DMem_rd) begin
            if (RD_LATENCY == 1) begin
                ram_en_s  = 1'b1;
                ram_clr_s = !in_range_s;
            end else begin
                ram_en_s  = 1'b0;
            end
        end else if (accept_s) begin
            ram_en_s = in_range_s;
            ram_we_s = in_range_s;
        end else begin
            ram_en_s = 1'b0;
        end
    end

    // Request FSM with registered handshake pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            addr_r      <= {ADDR_BITS{1'b0}};
            oor_r       <= 1'b0;
            rd_valid_r  <= 1'b0;
            wr_ack_r    <= 1'b0;
            mem_ready_r <= 1'b1;
            addr_err_r  <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            wr_ack_r   <= 1'b0;
            addr_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_err_r <= !in_range_s;
                        if (DMem_rd) begin
                            if (RD_LATENCY == 1) begin
                                rd_valid_r <= 1'b1;
                            end else begin
                                state_r     <= WAIT;
                                cnt_r       <= CNT_LOAD;
                                mem_ready_r <= 1'b0;
                                addr_r      <= DMem_addr[ADDR_BITS-1:0];
                                oor_r       <= !in_range_s;
                            end
                        end else begin
                            wr_ack_r <= in_range_s;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r     <= IDLE;
                        rd_valid_r  <= 1'b1;
                        mem_ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    mem_ready_r <= 1'b1;
                end
            endcase
        end
    end

    dmem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clock),
        .rst_n (reset),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .clr   (ram_clr_s),
        .addr  (ram_addr_s),
        .din   (Dmem_din),
        .q     (ram_q_s)
    );

    assign memout    = ram_q_s;
    assign rd_valid  = rd_valid_r;
    assign wr_ack    = wr_ack_r;
    assign mem_ready = mem_ready_r;
    assign addr_err  = addr_err_r;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning log2 of the memory depth in 16-bit words (256 words).
REQ-002 SHALL have parameter RD_LATENCY, default 2, meaning the read latency in clocks (legal values 1..4).
REQ-003 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port DMem_en, input, 1, request strobe from the memaccess stage.
REQ-006 SHALL have port DMem_addr, input, 16, word address.
REQ-007 SHALL have port Dmem_din, input, 16, write data.
REQ-008 SHALL have port DMem_rd, input, 1, 1=read, 0=write.
REQ-009 SHALL have port memout, output, 16, read data, held until the next read completes.
REQ-010 SHALL have port rd_valid, output, 1, one-cycle pulse marking new memout.
REQ-011 SHALL have port wr_ack, output, 1, one-cycle pulse confirming a committed write.
REQ-012 SHALL have port mem_ready, output, 1, high when a request can be accepted.
REQ-013 SHALL have port addr_err, output, 1, one-cycle pulse for an out-of-range access.

Function
REQ-014 SHALL accept a request at rising edge T0 when DMem_en=1 and mem_ready=1; otherwise DMem_en is ignored, with no state change.
REQ-015 SHALL treat address in range iff DMem_addr[15:ADDR_BITS]==0 and index the array with DMem_addr[ADDR_BITS-1:0].
REQ-016 SHALL commit an accepted in-range write at T0, assert wr_ack in the cycle after T0, and keep mem_ready=1.
REQ-017 SHALL register read data at edge T0+(RD_LATENCY-1), with rd_valid=1 for exactly that one cycle.
REQ-018 SHALL drive mem_ready low for RD_LATENCY-1 cycles after T0 and high again in the rd_valid cycle; with RD_LATENCY=1, mem_ready never drops.
REQ-019 SHALL implement FSM IDLE and WAIT.
- IDLE->WAIT on a read accept when RD_LATENCY>1; the down-counter is loaded with RD_LATENCY-2.
- WAIT->IDLE when the counter reaches 0, with rd_valid issued on that transition.
REQ-020 SHALL accept a new request in the rd_valid cycle (back-to-back).
REQ-021 SHALL return the newly written data for a read accepted the cycle after a write to the same address.
REQ-022 SHALL, on an out-of-range read, pulse addr_err in the cycle after T0, still complete with memout=16'h0000, and pulse rd_valid at normal latency.
REQ-023 SHALL discard an out-of-range write and pulse addr_err, not wr_ack, in the cycle after T0.
REQ-024 SHALL sample address and data only at accept; input changes while in WAIT do not affect the result.
REQ-025 SHALL never assert rd_valid and wr_ack in the same cycle.

Reset
REQ-026 SHALL, while reset=0, force memout=16'h0000, rd_valid=0, wr_ack=0, addr_err=0, mem_ready=1, state=IDLE, counter=0, asynchronously.
REQ-027 SHALL abort a read in flight at reset, with no rd_valid after reset release.
REQ-028 SHALL leave array contents unaffected by reset (not initialized).
REQ-029 SHALL accept requests from the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place the state enum (IDLE, WAIT), DATA_W=16, and the RD_LATENCY legal-range constants in shared package dmem_responder_pkg.
REQ-031 SHALL use one sub-module, dmem_array: single-port synchronous 2**ADDR_BITS x 16 RAM with write enable and registered read.
REQ-032 SHALL check RD_LATENCY in 1..4 at elaboration, with a fatal error otherwise.

Verification
REQ-033 SHALL cover write-then-read: write 16'hBEEF @ 16'h0012, read 16'h0012 (RD_LATENCY=2) -> wr_ack 1 cycle after write; rd_valid 1 cycle after read accept, memout=16'hBEEF, mem_ready low 1 cycle.
REQ-034 SHALL cover back-to-back reads: reads of 16'h0001 then 16'h0002 (holding 16'h1111, 16'h2222) at RD_LATENCY=3 -> second accepted in the first rd_valid cycle; memout 16'h1111 then 16'h2222, 3 cycles apart.
REQ-035 SHALL cover out-of-range access: read 16'h0100 -> addr_err pulse, memout=16'h0000, rd_valid at latency; write 16'h0100 -> addr_err, no wr_ack, 16'h0000 unchanged.
REQ-036 SHALL cover a busy request: DMem_en held with new addr 16'h0005 during WAIT -> ignored until mem_ready=1, then accepted once.
REQ-037 SHALL cover reset mid-read: reset=0 one cycle after read accept at RD_LATENCY=4 -> outputs at reset values; no rd_valid; a subsequent read of 16'h0012 returns 16'hBEEF.
REQ-038 SHALL cover RD_LATENCY=1: alternating write/read every cycle to 16'h00FF -> mem_ready constantly 1; each read returns the prior write.
